// File: rtl/led_effects_driver.sv
// led_effects_driver: per-LED blink and global PWM conditioning of the LED PIO word, with an Avalon-MM control slave.
module led_effects_driver #(
  parameter int WIDTH    = 19,
  parameter int PRESCALE = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] led_in,
  output logic [WIDTH-1:0] led_out
);
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] mask_q, mask_d, led_q, led_d;
  logic [7:0]       duty_q, duty_d, pwm_q, pwm_d;
  logic [15:0]      half_q, half_d, cnt_q, cnt_d, half_m1;
  logic             phase_q, phase_d, tick, wr, pwm_on, resync, half_wr;
  assign wr      = chipselect & ~write_n;
  assign tick    = presc_q == PW'(PRESCALE - 1);
  assign half_wr = wr && address == 2'd2;
  assign resync  = wr && address == 2'd3 && writedata[0];
  // a half-period of 0 behaves like 1, so the terminal count is 0 in both cases
  assign half_m1 = (half_q == 16'd0) ? 16'd0 : half_q - 16'd1;
  assign pwm_on  = (duty_q == 8'hFF) | (pwm_q < duty_q);
  assign led_out = led_q;
  assign readdata = (address == 2'd0) ? 32'(mask_q) :
                    (address == 2'd1) ? {24'd0, duty_q} :
                    (address == 2'd2) ? {16'd0, half_q} : {31'd0, phase_q};
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    pwm_d   = pwm_q + 8'd1;
    mask_d  = (wr && address == 2'd0) ? writedata[WIDTH-1:0] : mask_q;
    duty_d  = (wr && address == 2'd1) ? writedata[7:0] : duty_q;
    half_d  = half_wr ? writedata[15:0] : half_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (half_wr || resync) begin
      cnt_d   = 16'd0;
      phase_d = resync ? 1'b1 : phase_q;
    end else if (tick) begin
      cnt_d   = (cnt_q == half_m1) ? 16'd0 : cnt_q + 16'd1;
      phase_d = (cnt_q == half_m1) ? ~phase_q : phase_q;
    end
    led_d = led_in & {WIDTH{pwm_on}} & (~mask_q | {WIDTH{phase_q}});
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      pwm_q   <= 8'd0;
      mask_q  <= '0;
      duty_q  <= 8'hFF;
      half_q  <= 16'd250;
      cnt_q   <= 16'd0;
      phase_q <= 1'b1;
      led_q   <= '0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      mask_q  <= mask_d;
      duty_q  <= duty_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end
endmodule

// File: tb/tb_led_effects_driver.sv
// tb_led_effects_driver: directed and random stimulus against a time-based reference model of led_effects_driver.
module tb_led_effects_driver;
  localparam int W = 19, P = 4;
  logic clk = 1'b0, reset, cs, wn;
  logic [1:0] addr;
  logic [31:0] wd, rd;
  logic [W-1:0] led_in, led_out;
  int checks = 0, failures = 0;
  int cyc = 0, k = 0;
  logic base = 1'b1;
  logic [15:0] half_m = 16'd250;
  logic [7:0] duty_m = 8'hFF;
  logic [W-1:0] mask_m = '0, exp_led = '0;
  always #5 clk = ~clk;
  led_effects_driver #(.WIDTH(W), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .address(addr), .chipselect(cs), .write_n(wn),
    .writedata(wd), .readdata(rd), .led_in(led_in), .led_out(led_out)
  );
  // phase flips after every max(half,1) ticks since the last restart point
  function automatic logic ph();
    int h = (half_m == 16'd0) ? 1 : int'(half_m);
    return base ^ ((k / h) % 2 == 1);
  endfunction
  function automatic logic [31:0] exp_rd();
    case (addr)
      2'd0:    return 32'(mask_m);
      2'd1:    return {24'd0, duty_m};
      2'd2:    return {16'd0, half_m};
      default: return {31'd0, ph()};
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    logic tk, pon, p;
    @(posedge clk);
    p   = ph();
    tk  = (cyc % P) == P - 1;
    pon = duty_m == 8'hFF || (cyc % 256) < int'(duty_m);
    if (reset) begin
      cyc = 0; k = 0; base = 1'b1; half_m = 16'd250; duty_m = 8'hFF; mask_m = '0; exp_led = '0;
    end else begin
      exp_led = led_in & {W{pon}} & (~mask_m | {W{p}});
      if (cs && !wn && addr == 2'd0) mask_m = wd[W-1:0];
      if (cs && !wn && addr == 2'd1) duty_m = wd[7:0];
      if (cs && !wn && addr == 2'd2) begin half_m = wd[15:0]; k = 0; base = p; end
      else if (cs && !wn && addr == 2'd3 && wd[0]) begin k = 0; base = 1'b1; end
      else if (tk) k++;
      cyc++;
    end
    #1;
    chk("led_out", 32'(led_out), 32'(exp_led));
    chk("readdata", rd, exp_rd());
  endtask
  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; wn = 1'b0; addr = a; wd = d;
    step();
    cs = 1'b0; wn = 1'b1;
  endtask
  // checks the first two complete runs of led_out[0] against the expected length
  task automatic runs(input string tag, input int n, input int len);
    int t[$];
    logic prev;
    step();
    prev = led_out[0];
    for (int i = 1; i < n; i++) begin
      step();
      if (led_out[0] !== prev) t.push_back(i);
      prev = led_out[0];
    end
    if (t.size() < 3) chk(tag, 32'(t.size()), 32'd3);
    else begin
      chk(tag, 32'(t[1] - t[0]), 32'(len));
      chk(tag, 32'(t[2] - t[1]), 32'(len));
    end
  endtask
  task automatic pwm_count(input string tag, input logic [7:0] d, input int exp_on);
    int on = 0;
    wr_reg(2'd1, {24'd0, d});
    for (int i = 0; i < 256; i++) begin
      step();
      if (led_out === {W{1'b1}}) on++;
    end
    chk(tag, 32'(on), 32'(exp_on));
  endtask
  initial begin
    logic p0;
    reset = 1'b1; cs = 1'b0; wn = 1'b1; addr = 2'd0; wd = '0; led_in = '0;
    step(); step();
    chk("reset_led", 32'(led_out), 32'd0);
    reset = 1'b0;
    led_in = 19'h5A5A5;
    step(); step();
    chk("default_led", 32'(led_out), 32'h5A5A5);
    addr = 2'd1; #1 chk("default_duty", rd, 32'hFF);
    addr = 2'd2; #1 chk("default_half", rd, 32'd250);
    addr = 2'd3; #1 chk("default_status", rd, 32'h1);
    led_in = 19'h12345; step();
    chk("follow_led", 32'(led_out), 32'h12345);
    // blinking with a 3-tick half period
    wr_reg(2'd2, 32'd3);
    wr_reg(2'd0, 32'h00001);
    led_in = 19'h00003;
    wr_reg(2'd3, 32'd1);
    addr = 2'd3;
    runs("blink_run", 80, 12);
    // PWM brightness
    wr_reg(2'd0, 32'd0);
    led_in = '1;
    pwm_count("pwm_64", 8'd64, 64);
    pwm_count("pwm_0", 8'd0, 0);
    pwm_count("pwm_255", 8'd255, 256);
    // half-period write landing on a tick keeps the phase
    wr_reg(2'd0, 32'h1);
    for (int i = 0; i < 20 && (cyc % P) != P - 1; i++) step();
    p0 = ph();
    wr_reg(2'd2, 32'd2);
    addr = 2'd3; #1 chk("collision_phase", rd, {31'd0, p0});
    for (int i = 0; i < 10; i++) step();
    wr_reg(2'd3, 32'd1);
    addr = 2'd3; #1 chk("resync_phase", rd, 32'd1);
    for (int i = 0; i < 12; i++) step();
    // half-period 0 toggles on every tick
    led_in = 19'h00001;
    wr_reg(2'd2, 32'd0);
    runs("half0_run", 40, P);
    // reset in the middle of a low blink phase with a dim duty
    wr_reg(2'd1, 32'd10);
    wr_reg(2'd2, 32'd1);
    led_in = 19'h7FFFF;
    for (int i = 0; i < 20 && ph() != 1'b0; i++) step();
    chk("pre_reset_phase", {31'd0, ph()}, 32'd0);
    reset = 1'b1; step(); reset = 1'b0;
    chk("reset_mid_led", 32'(led_out), 32'd0);
    step();
    chk("post_reset_led", 32'(led_out), 32'h7FFFF);
    addr = 2'd1; #1 chk("post_reset_duty", rd, 32'hFF);
    addr = 2'd3; #1 chk("post_reset_phase", rd, 32'h1);
    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      reset  = ($urandom_range(0, 399) == 0);
      cs     = 1'($urandom_range(0, 1));
      wn     = ($urandom_range(0, 3) != 0);
      addr   = 2'($urandom_range(0, 3));
      wd     = (addr == 2'd2) ? 32'($urandom_range(0, 5)) : $urandom;
      led_in = W'($urandom);
      step();
    end
    reset = 1'b0; cs = 1'b0; wn = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_effects_driver.md
Name: led_effects_driver

Overview:
- Output-conditioning stage directly downstream of the LED PIO: consumes the PIO's 19-bit LED word and drives the board LED pins.
- Adds per-LED blinking and global PWM brightness, controlled through its own small Avalon-MM slave so Nios II software can set effects without rewriting the LED word.
- Combinational read path and zero-extended readdata, consistent with the PIO.

Parameters:
- WIDTH, 19, number of LEDs; width of led_in/led_out/blink mask.
- PRESCALE, 50000, clk cycles per blink tick (1 ms at 50 MHz); must be >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational
- led_in  in  WIDTH  LED word from the LED PIO out_port
- led_out  out  WIDTH  conditioned LED drive, registered

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on posedge clk; reset has priority over everything.
- Register map. A write occurs when chipselect & ~write_n.
  - Addr 0 BLINK_MASK[WIDTH-1:0], RW, reset 0.
  - Addr 1 DUTY[7:0], RW, reset 8'hFF.
  - Addr 2 BLINK_HALF[15:0], RW, reset 250: half-period in ticks. Value 0 is treated as 1.
  - Addr 3 STATUS, RO: bit0 = blink_phase. Writing 1 to writedata[0] resyncs: blink_cnt<=0, blink_phase<=1.
- readdata = selected register zero-extended to 32 bits. It is valid in the same cycle and ignores chipselect. Unused bits read 0.
- Prescaler: presc_cnt counts 0..PRESCALE-1 and wraps. tick = 1 for exactly one cycle when presc_cnt==PRESCALE-1. Reset value 0.
- Blink timer (reset blink_cnt=0, blink_phase=1):
  - On tick: if blink_cnt == max(BLINK_HALF,1)-1, then blink_cnt<=0 and blink_phase toggles; else blink_cnt increments.
  - A write to addr 2 forces blink_cnt<=0 and leaves the phase unchanged. A write to addr 2 or a resync in the same cycle as tick wins over the tick.
- PWM:
  - pwm_cnt is 8 bits, increments every clk, wraps 255->0. Reset value 0.
  - pwm_on = (DUTY==8'hFF) | (pwm_cnt < DUTY). So DUTY=0 means always off, 255 means always on, and N gives N of every 256 cycles on.
  - A DUTY change takes effect on the next cycle. No wait for the period boundary.
- Output: led_out[i] <= led_in[i] & pwm_on & (~BLINK_MASK[i] | blink_phase).
  - Latency: 1 cycle from led_in/pwm_on/phase to led_out.
  - Reset value of led_out is 0.
- Reset asserted mid-operation: all counters, registers and led_out return to reset values on that edge. The first led_out update after reset release reflects DUTY=FF, mask=0, i.e. led_out == led_in delayed 1 cycle.
- Widths: BLINK_MASK write uses writedata[WIDTH-1:0]. DUTY uses [7:0]. BLINK_HALF uses [15:0]. Upper bits are ignored.

Test Plan:
- Reset then defaults: led_in=19'h5A5A5, no writes -> led_out=19'h5A5A5 one cycle after each led_in change; readdata at addr1=32'hFF, addr2=32'd250, addr3=32'h1.
- Blink, PRESCALE=4 in bench: write BLINK_HALF=3, BLINK_MASK=19'h00001, led_in=19'h00003 -> bit0 toggles every 12 cycles, starting with 12 cycles high; bit1 stays 1; STATUS bit0 tracks the phase.
- PWM: DUTY=64, led_in=all ones -> led_out high exactly 64 of every 256 cycles. DUTY=0 -> led_out constantly 0. DUTY=255 -> constantly all ones.
- Write/tick collision: write addr2 in the same cycle tick=1 -> blink_cnt=0 next cycle, phase unchanged. Write addr3 data=1 mid-period -> phase=1 and full half-period restarts.
- BLINK_HALF=0: masked LED toggles every tick (every PRESCALE=4 cycles).
- Reset mid-blink with phase=0 and DUTY=10: assert reset for 1 cycle -> next cycle led_out=0, then led_out==led_in; DUTY reads 255, phase reads 1.
